// File: rtl/alu_inst_encoder_if.sv
// Request/response bundle for the ALU instruction encoder.
// The master side issues requests and consumes words. The slave side is the encoder.
interface alu_inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_op;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        output in_valid, in_alu_op, in_use_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, err, err_cnt
    );

    modport slave (
        input  in_valid, in_alu_op, in_use_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, err, err_cnt
    );
endinterface

// File: rtl/alu_inst_encoder.sv
// Encodes abstract ALU requests into RV32I R/I-type words through a 2-entry FIFO.
// Requests that have no encoding are dropped and counted in a sticky error flag and a saturating counter.
module alu_inst_encoder (
    input logic           clk,
    input logic           rst,
    alu_inst_encoder_if.slave bus
);
    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SL  = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [1:0][31:0] mem;
    logic [1:0]       cnt;
    logic             wptr, rptr;
    logic [7:0]       err_cnt_q;
    logic             err_q;

    logic        legal;
    logic [31:0] word;
    logic        accept, push, pop;

    // Operand 2 is either rs2 or the immediate. For shifts, only the 5-bit shamt is placed.
    always_comb begin
        legal = 1'b0;
        word  = '0;
        if (bus.in_use_imm) begin
            case (bus.in_alu_op)
                OP_ADD: begin
                    legal = 1'b1;
                    word  = {bus.in_imm, bus.in_rs1, 3'b000, bus.in_rd, OPC_IMM};
                end
                OP_SL: begin
                    legal = 1'b1;
                    word  = {7'b0, bus.in_imm[4:0], bus.in_rs1, 3'b001, bus.in_rd, OPC_IMM};
                end
                OP_SRL: begin
                    legal = 1'b1;
                    word  = {7'b0, bus.in_imm[4:0], bus.in_rs1, 3'b101, bus.in_rd, OPC_IMM};
                end
                OP_SRA: begin
                    legal = 1'b1;
                    word  = {F7_ALT, bus.in_imm[4:0], bus.in_rs1, 3'b101, bus.in_rd, OPC_IMM};
                end
                default: legal = 1'b0;
            endcase
        end else begin
            case (bus.in_alu_op)
                OP_ADD: begin
                    legal = 1'b1;
                    word  = {7'b0, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, OPC_REG};
                end
                OP_SUB: begin
                    legal = 1'b1;
                    word  = {F7_ALT, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, OPC_REG};
                end
                OP_XOR: begin
                    legal = 1'b1;
                    word  = {7'b0, bus.in_rs2, bus.in_rs1, 3'b100, bus.in_rd, OPC_REG};
                end
                OP_OR: begin
                    legal = 1'b1;
                    word  = {7'b0, bus.in_rs2, bus.in_rs1, 3'b110, bus.in_rd, OPC_REG};
                end
                OP_AND: begin
                    legal = 1'b1;
                    word  = {7'b0, bus.in_rs2, bus.in_rs1, 3'b111, bus.in_rd, OPC_REG};
                end
                default: legal = 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (cnt != 2'd2);
    assign bus.out_valid = (cnt != 2'd0);
    assign bus.out_inst  = mem[rptr];
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal;
    assign pop    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem       <= '0;
            cnt       <= 2'd0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (push) begin
                mem[wptr] <= word;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            if (accept && !legal) begin
                err_q <= 1'b1;
                if (err_cnt_q != 8'd255)
                    err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_inst_encoder.sv
// Directed bench for alu_inst_encoder. Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_alu_inst_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_inst_encoder_if bus();

    alu_inst_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic ui,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [11:0] imm);
        bus.in_valid   = v;
        bus.in_alu_op  = op;
        bus.in_use_imm = ui;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm     = imm;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", bus.out_inst); end
        checks++; if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", bus.err, bus.err_cnt); end
    endtask

    task automatic test_add_latency();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b001, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        cyc();
        drive(1'b0, 3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h002081B3) begin failures++; $display("FAIL add_word got=%b/%h exp=1/002081b3", bus.out_valid, bus.out_inst); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL add_err got=%b exp=0", bus.err); end
        cyc();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3] = '{32'h407302B3, 32'hFFF00093, 32'h4035D513};
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 12'h0);
        cyc();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== exp[0]) begin failures++; $display("FAIL b2b_0 got=%h exp=%h", bus.out_inst, exp[0]); end
        drive(1'b1, 3'b001, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF);
        cyc();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== exp[1]) begin failures++; $display("FAIL b2b_1 got=%h exp=%h", bus.out_inst, exp[1]); end
        drive(1'b1, 3'b111, 1'b1, 5'd10, 5'd11, 5'd0, 12'h003);
        cyc();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== exp[2]) begin failures++; $display("FAIL b2b_2 got=%h exp=%h", bus.out_inst, exp[2]); end
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        cyc();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    endtask

    // Unused fields are driven with garbage to confirm that they are ignored.
    task automatic test_encodings();
        logic [2:0]  op  [6] = '{3'b110, 3'b010, 3'b011, 3'b100, 3'b101, 3'b001};
        logic        ui  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0]  rd  [6] = '{5'd2, 5'd1, 5'd4, 5'd7, 5'd31, 5'd9};
        logic [4:0]  rs1 [6] = '{5'd2, 5'd2, 5'd5, 5'd8, 5'd31, 5'd4};
        logic [4:0]  rs2 [6] = '{5'd17, 5'd3, 5'd6, 5'd9, 5'd21, 5'd30};
        logic [11:0] imm [6] = '{12'hFFF, 12'hABC, 12'h555, 12'hFFF, 12'h01F, 12'h800};
        logic [31:0] exp [6] = '{32'h01F11113, 32'h003170B3, 32'h0062E233,
                                 32'h009443B3, 32'h01FFDF93, 32'h80020493};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, op[i], ui[i], rd[i], rs1[i], rs2[i], imm[i]);
            cyc();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_inst !== exp[i]) begin
                failures++; $display("FAIL enc_%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_inst, exp[i]);
            end
        end
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        cyc();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
        cyc();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", bus.in_ready); end
        drive(1'b1, 3'b001, 1'b0, 5'd2, 5'd2, 5'd2, 12'h0);
        cyc();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", bus.in_ready); end
        drive(1'b1, 3'b100, 1'b0, 5'd7, 5'd8, 5'd9, 12'h0);
        cyc();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_inst !== 32'h001080B3) begin failures++; $display("FAIL bp_hold got=%b/%h exp=0/001080b3", bus.in_ready, bus.out_inst); end
        bus.out_ready = 1'b1;
        cyc();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_inst !== 32'h00210133) begin failures++; $display("FAIL bp_pop1 got=%b/%h exp=1/00210133", bus.in_ready, bus.out_inst); end
        cyc();
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h009443B3) begin failures++; $display("FAIL bp_pop2 got=%b/%h exp=1/009443b3", bus.out_valid, bus.out_inst); end
        cyc();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 12'h1);
        cyc();
        drive(1'b1, 3'b101, 1'b0, 5'd1, 5'd2, 5'd3, 12'h1);
        cyc();
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ill_nowrite got=%b exp=0", bus.out_valid); end
        checks++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'd2) begin failures++; $display("FAIL ill_count got=%b/%0d exp=1/2", bus.err, bus.err_cnt); end
        // Legal push followed by an illegal accept that coincides with the pop.
        drive(1'b1, 3'b001, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0);
        cyc();
        drive(1'b1, 3'b010, 1'b1, 5'd3, 5'd1, 5'd2, 12'h0);
        cyc();
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        checks++; if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd3) begin failures++; $display("FAIL ill_pop got=%b/%0d exp=0/3", bus.out_valid, bus.err_cnt); end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, (i % 2 == 0) ? 3'b110 : 3'b111, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
            cyc();
        end
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        checks++; if (bus.err_cnt !== 8'd255 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL ill_sat got=%0d/%b exp=255/0", bus.err_cnt, bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
        cyc();
        drive(1'b1, 3'b001, 1'b0, 5'd2, 5'd2, 5'd2, 12'h0);
        cyc();
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL rm_pre got=%b/%b exp=1/0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rm_flush got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.err_cnt !== 8'd0 || bus.err !== 1'b0) begin failures++; $display("FAIL rm_err got=%b/%0d exp=0/0", bus.err, bus.err_cnt); end
        // Requests presented while reset is held must be neither enqueued nor counted.
        rst = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd1, 5'd1, 12'h0);
        cyc();
        drive(1'b1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        checks++; if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd0) begin failures++; $display("FAIL rm_ignored got=%b/%0d exp=0/0", bus.out_valid, bus.err_cnt); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_encodings();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
